// File: rtl/btn_debounce_counter.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release strobes,
// press counter and per-press LED toggle. Single clock domain, synchronous active-low reset.
module btn_debounce_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             btn_raw,
    input  logic             clr,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             led
);

    localparam int unsigned         STAB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [STAB_W-1:0]   STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        CHK_HIGH,
        IDLE_HIGH,
        CHK_LOW
    } state_t;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    state_t            state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              btn_level_q, btn_level_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic [CNT_W-1:0]  press_count_q, press_count_d;
    logic              led_q, led_d;

    always_comb begin
        // synchroniser runs regardless of ena
        sync1_d         = btn_raw;
        sync2_d         = sync1_q;
        state_d         = state_q;
        stab_cnt_d      = stab_cnt_q;
        btn_level_d     = btn_level_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        press_count_d   = press_count_q;
        led_d           = led_q;

        if (ena) begin
            unique case (state_q)
                IDLE_LOW: begin
                    if (sync2_q) begin
                        state_d    = CHK_HIGH;
                        stab_cnt_d = '0;
                    end
                end
                CHK_HIGH: begin
                    if (!sync2_q) begin
                        state_d    = IDLE_LOW;
                        stab_cnt_d = '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_d       = IDLE_HIGH;
                        stab_cnt_d    = '0;
                        btn_level_d   = 1'b1;
                        press_pulse_d = 1'b1;
                        press_count_d = press_count_q + CNT_W'(1);
                        led_d         = ~led_q;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!sync2_q) begin
                        state_d    = CHK_LOW;
                        stab_cnt_d = '0;
                    end
                end
                CHK_LOW: begin
                    if (sync2_q) begin
                        state_d    = IDLE_HIGH;
                        stab_cnt_d = '0;
                    end else if (stab_cnt_q == STAB_LAST) begin
                        state_d         = IDLE_LOW;
                        stab_cnt_d      = '0;
                        btn_level_d     = 1'b0;
                        release_pulse_d = 1'b1;
                    end else begin
                        stab_cnt_d = stab_cnt_q + STAB_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE_LOW;
                    stab_cnt_d = '0;
                end
            endcase
        end

        // clear overrides a simultaneous press increment, independent of ena
        if (clr) begin
            press_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            state_q         <= IDLE_LOW;
            stab_cnt_q      <= '0;
            btn_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= '0;
            led_q           <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            stab_cnt_q      <= stab_cnt_d;
            btn_level_q     <= btn_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
            led_q           <= led_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;
    assign led           = led_q;

endmodule

// File: tb/tb_btn_debounce_counter.sv
// Bench for btn_debounce_counter: per-cycle scoreboard against a run-length model,
// a segment table with hand-derived end states, and directed latency/reset sequences.
module tb_btn_debounce_counter;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n, ena, btn_raw, clr;
    logic       btn_level, press_pulse, release_pulse, led;
    logic [7:0] press_count;
    logic       btn_level2, press_pulse2, release_pulse2, led2;
    logic [1:0] press_count2;

    always #5 clk = ~clk;

    btn_debounce_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw), .clr(clr),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .press_count(press_count), .led(led)
    );

    btn_debounce_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw), .clr(clr),
        .btn_level(btn_level2), .press_pulse(press_pulse2), .release_pulse(release_pulse2),
        .press_count(press_count2), .led(led2)
    );

    int checks = 0;
    int errors = 0;
    int seen_press = 0;
    int seen_release = 0;

    // Model: level flips once s2 has disagreed with it on D+1 consecutive enabled edges.
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0, m_led = 1'b0;
    logic [7:0] m_cnt = '0;
    int         m_run = 0;

    typedef struct packed {
        logic       lvl;
        logic       pp;
        logic       rp;
        logic [7:0] cnt;
        logic       led;
        logic [1:0] cnt2;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_edge();
        exp_t e;
        logic pp, rp;
        pp = 1'b0;
        rp = 1'b0;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_lvl = 1'b0; m_cnt = '0; m_led = 1'b0;
        end else begin
            if (ena) begin
                m_run = (m_s2 != m_lvl) ? m_run + 1 : 0;
                if (m_run == int'(D) + 1) begin
                    m_run = 0;
                    m_lvl = ~m_lvl;
                    if (m_lvl) begin
                        pp = 1'b1; m_led = ~m_led; m_cnt = m_cnt + 8'd1;
                    end else begin
                        rp = 1'b1;
                    end
                end
            end
            if (clr) m_cnt = '0;
            m_s2 = m_s1;
            m_s1 = btn_raw;
        end
        e = '{lvl: m_lvl, pp: pp, rp: rp, cnt: m_cnt, led: m_led, cnt2: m_cnt[1:0]};
        sb_q.push_back(e);
    endtask

    // Inputs are stable here; the next posedge consumes them.
    task automatic step();
        model_edge();
        @(negedge clk);
        if (press_pulse === 1'b1) seen_press++;
        if (release_pulse === 1'b1) seen_release++;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e, g;
            e = sb_q.pop_front();
            g = '{lvl: btn_level, pp: press_pulse, rp: release_pulse, cnt: press_count,
                  led: led, cnt2: press_count2};
            checks++;
            if (g !== e || press_pulse2 !== e.pp || release_pulse2 !== e.rp ||
                btn_level2 !== e.lvl || led2 !== e.led) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got lvl=%b pp=%b rp=%b cnt=%0d led=%b cnt2=%0d, expected lvl=%b pp=%b rp=%b cnt=%0d led=%b cnt2=%0d",
                         $time, g.lvl, g.pp, g.rp, g.cnt, g.led, g.cnt2,
                         e.lvl, e.pp, e.rp, e.cnt, e.led, e.cnt2);
            end
        end
    end

    // Drives until the named pulse appears; returns edges taken (0 on timeout).
    task automatic wait_pulse(input bit want_press, input int bound, output int edges);
        int p0, r0;
        p0 = seen_press;
        r0 = seen_release;
        edges = 0;
        for (int n = 1; n <= bound; n++) begin
            step();
            if ((want_press && seen_press != p0) || (!want_press && seen_release != r0)) begin
                edges = n;
                break;
            end
        end
    endtask

    typedef struct {
        logic        raw;
        logic        en;
        logic        cl;
        int unsigned cycles;
        int unsigned presses;
        int unsigned releases;
        logic        lvl;
        int unsigned cnt;
        int unsigned cnt2;
        logic        led_e;
    } seg_t;

    seg_t segs[16];

    initial begin
        int n, p0, r0;

        //         raw en cl cyc  p  r lvl cnt c2 led
        segs[0]  = '{1, 1, 0, 8,  1, 0, 1, 2, 2, 0};
        segs[1]  = '{0, 1, 0, 8,  0, 1, 0, 2, 2, 0};
        segs[2]  = '{1, 1, 0, 8,  1, 0, 1, 3, 3, 1};
        segs[3]  = '{0, 1, 0, 8,  0, 1, 0, 3, 3, 1};
        segs[4]  = '{1, 1, 0, 8,  1, 0, 1, 4, 0, 0};
        segs[5]  = '{0, 1, 0, 8,  0, 1, 0, 4, 0, 0};
        segs[6]  = '{1, 1, 0, 8,  1, 0, 1, 5, 1, 1};
        segs[7]  = '{0, 1, 0, 8,  0, 1, 0, 5, 1, 1};
        segs[8]  = '{0, 1, 1, 2,  0, 0, 0, 0, 0, 1};
        segs[9]  = '{1, 1, 0, 3,  0, 0, 0, 0, 0, 1};
        segs[10] = '{1, 0, 0, 4,  0, 0, 0, 0, 0, 1};
        segs[11] = '{1, 1, 0, 8,  1, 0, 1, 1, 1, 0};
        segs[12] = '{0, 0, 0, 10, 0, 0, 1, 1, 1, 0};
        segs[13] = '{0, 1, 0, 8,  0, 1, 0, 1, 1, 0};
        segs[14] = '{1, 1, 1, 8,  1, 0, 1, 0, 0, 1};
        segs[15] = '{0, 1, 0, 8,  0, 1, 0, 0, 0, 1};

        rst_n = 1'b0; ena = 1'b1; btn_raw = 1'b0; clr = 1'b0;
        step(); step();
        check("reset_outputs", {btn_level, press_pulse, release_pulse, press_count, led}, 0);
        check("reset_count2", press_count2, 0);
        rst_n = 1'b1;
        step(); step();

        // First press: E0 is the first edge sampling raw=1; strobe lands after E0+6
        btn_raw = 1'b1;
        wait_pulse(1'b1, 20, n);
        check("press_latency_edges", n, 7);
        check("press_level", btn_level, 1);
        check("press_count_1", press_count, 1);
        check("press_led", led, 1);
        step();
        check("press_pulse_one_cycle", press_pulse, 0);

        btn_raw = 1'b0;
        wait_pulse(1'b0, 20, n);
        check("release_latency_edges", n, 7);
        check("release_level", btn_level, 0);
        check("release_count_holds", press_count, 1);

        foreach (segs[i]) begin
            btn_raw = segs[i].raw; ena = segs[i].en; clr = segs[i].cl;
            p0 = seen_press; r0 = seen_release;
            repeat (segs[i].cycles) step();
            check($sformatf("seg%0d_presses", i), seen_press - p0, segs[i].presses);
            check($sformatf("seg%0d_releases", i), seen_release - r0, segs[i].releases);
            check($sformatf("seg%0d_level", i), btn_level, segs[i].lvl);
            check($sformatf("seg%0d_count", i), press_count, segs[i].cnt);
            check($sformatf("seg%0d_count2", i), press_count2, segs[i].cnt2);
            check($sformatf("seg%0d_led", i), led, segs[i].led_e);
        end
        ena = 1'b1; clr = 1'b0;

        // Enable held low for three edges while qualifying: strobe slips to E0+9
        btn_raw = 1'b1;
        n = 0;
        p0 = seen_press;
        for (int k = 1; k <= 30; k++) begin
            ena = (k >= 4 && k <= 6) ? 1'b0 : 1'b1;
            step();
            if (seen_press != p0) begin
                n = k;
                break;
            end
        end
        ena = 1'b1;
        check("ena_gap_latency_edges", n, 10);
        check("ena_gap_count", press_count, 1);
        btn_raw = 1'b0;
        repeat (8) step();

        // clr exactly on the accepting edge
        btn_raw = 1'b1;
        repeat (6) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_press_pulse", press_pulse, 1);
        check("clr_wins_count", press_count, 0);
        check("clr_led_toggles", led, 1);
        btn_raw = 1'b0;
        repeat (8) step();

        // 3-high/3-low bounce never qualifies
        p0 = seen_press; r0 = seen_release;
        repeat (10) begin
            btn_raw = 1'b1; repeat (3) step();
            btn_raw = 1'b0; repeat (3) step();
        end
        repeat (8) step();
        check("bounce_presses", seen_press - p0, 0);
        check("bounce_releases", seen_release - r0, 0);
        check("bounce_level", btn_level, 0);
        check("bounce_led", led, 1);

        // Reset mid-qualification discards the press in progress
        btn_raw = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("midreset_outputs", {btn_level, press_pulse, release_pulse, press_count, led}, 0);
        rst_n = 1'b1;
        wait_pulse(1'b1, 30, n);
        check("midreset_press_seen", (n != 0), 1);
        check("midreset_count", press_count, 1);
        check("midreset_led", led, 1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
